mport_fifo_cnt: RTL and testbench

//  Multi-port (WRITE-in / READ-out) FIFO, next generation of the team's multi-port fifo.

---
 rtl/mport_fifo_cnt.sv | 141 ++++++++++++++
 tb/tb_mport_fifo_cnt.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mport_fifo_cnt.sv
// Multi-port FIFO: up to WRITE compacted pushes and READ prefix pops per cycle, with occupancy and almost-full.
// Latency: data written at edge N is visible on rd after edge N; rd/v/busy/almost_full are combinational from state.
// Backpressure: all-or-nothing writes are dropped when they do not fit (sticky ovf_err); busy warns of < WRITE free slots.
module mport_fifo_cnt #(
  parameter int DATA      = 32,
  parameter int DEPTH     = 16,
  parameter int READ      = 4,
  parameter int WRITE     = 4,
  parameter int AF_THRESH = 12,
  parameter bit ACT       = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [WRITE-1:0]             we,
  input  logic [WRITE*DATA-1:0]        wd,
  input  logic [READ-1:0]              re,
  output logic [READ*DATA-1:0]         rd,
  output logic [READ-1:0]              v,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         almost_full,
  output logic                         ovf_err,
  output logic                         unf_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Sums of a pointer and an offset stay below 2*DEPTH, so one extra bit suffices.
  localparam int SW = CW + 1;

  logic [DATA-1:0]  mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt_q;

  logic             flush_act;
  logic [WRITE-1:0] we_act;
  logic [READ-1:0]  re_act;

  logic [SW-1:0]    nw;
  logic [SW-1:0]    free_slots;
  logic             wr_acc;
  logic             wr_drop;
  logic [PW-1:0]    wr_idx [WRITE];

  logic [SW-1:0]    nr_req;
  logic [SW-1:0]    nr;
  logic             rd_unf;

  assign flush_act = ACT ? flush : ~flush;
  assign we_act    = ACT ? we    : ~we;
  assign re_act    = ACT ? re    : ~re;

  // Pointer wrap for arbitrary DEPTH: operands are always < 2*DEPTH.
  function automatic logic [PW-1:0] wrap(input logic [SW-1:0] a);
    if (a >= SW'(DEPTH)) wrap = PW'(a - SW'(DEPTH));
    else                 wrap = PW'(a);
  endfunction

  // Compact enabled write ports in ascending order onto consecutive slots from tail.
  always_comb begin
    nw = '0;
    for (int i = 0; i < WRITE; i++) begin
      wr_idx[i] = wrap(SW'(tail) + nw);
      if (we_act[i]) nw = nw + SW'(1);
    end
    free_slots = SW'(DEPTH) - SW'(cnt_q);
    wr_acc     = (nw <= free_slots);
    wr_drop    = (nw > free_slots);
  end

  // Pop count is the leading run of enables from port 0; stray bits or over-reads flag underflow.
  always_comb begin
    logic run;
    logic stray;
    nr_req = '0;
    run    = 1'b1;
    stray  = 1'b0;
    for (int i = 0; i < READ; i++) begin
      if (re_act[i]) begin
        if (run) nr_req = nr_req + SW'(1);
        else     stray  = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    if (nr_req > SW'(cnt_q)) begin
      nr     = SW'(cnt_q);
      rd_unf = 1'b1;
    end else begin
      nr     = nr_req;
      rd_unf = stray;
    end
  end

  // Pointer, occupancy and sticky error state; reset beats flush, flush discards the cycle's requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      cnt_q   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (flush_act) begin
      head    <= '0;
      tail    <= '0;
      cnt_q   <= '0;
    end else begin
      head  <= wrap(SW'(head) + nr);
      if (wr_acc) tail <= wrap(SW'(tail) + nw);
      cnt_q <= CW'(SW'(cnt_q) + (wr_acc ? nw : SW'(0)) - nr);
      if (wr_drop) ovf_err <= 1'b1;
      if (rd_unf)  unf_err <= 1'b1;
    end
  end

  // Storage is never cleared; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (!reset && !flush_act && wr_acc) begin
      for (int i = 0; i < WRITE; i++) begin
        if (we_act[i]) mem[wr_idx[i]] <= wd[i*DATA +: DATA];
      end
    end
  end

  // Head window: entry i is valid while occupancy exceeds i, invalid lanes read as zero.
  always_comb begin
    rd = '0;
    v  = '0;
    for (int i = 0; i < READ; i++) begin
      v[i] = (SW'(cnt_q) > SW'(i));
      if (v[i]) rd[i*DATA +: DATA] = mem[wrap(SW'(head) + SW'(i))];
    end
  end

  assign count       = cnt_q;
  assign busy        = (SW'(DEPTH) - SW'(cnt_q)) < SW'(WRITE);
  assign almost_full = SW'(cnt_q) >= SW'(AF_THRESH);

endmodule

// File: tb/tb_mport_fifo_cnt.sv
// Bench for mport_fifo_cnt: directed cycles queue hand-computed expected state,
// a monitor on the falling edge pops and compares each snapshot.
// Enables and flush are active-low at the pins; the driver takes active-high masks.
module tb_mport_fifo_cnt;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [3:0]    we;
  logic [127:0]  wd;
  logic [3:0]    re;
  logic [127:0]  rd;
  logic [3:0]    v;
  logic [4:0]    count;
  logic          busy;
  logic          almost_full;
  logic          ovf_err;
  logic          unf_err;

  int ntests = 0;
  int nfail  = 0;

  typedef struct packed {
    logic [7:0]   tid;
    logic [4:0]   cnt;
    logic [127:0] r;
    logic         o;
    logic         u;
  } exp_t;

  exp_t sb [$];

  localparam logic [31:0] J = 32'hDEAD_BEEF;
  localparam logic [31:0] A = 32'hA000_000A;
  localparam logic [31:0] C = 32'hC000_000C;

  mport_fifo_cnt #(
    .DATA(32), .DEPTH(16), .READ(4), .WRITE(4), .AF_THRESH(12), .ACT(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .we(we), .wd(wd), .re(re),
    .rd(rd), .v(v), .count(count), .busy(busy), .almost_full(almost_full),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int tid, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL t%0d %s got %h expected %h", tid, nm, got, exp);
    end
  endtask

  // Monitor: compares the state after each driven edge against the queued expectation.
  initial begin
    exp_t e;
    logic [3:0] ev;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) ev[i] = (int'(e.cnt) > i);
        chk("count", int'(e.tid), 32'(count), 32'(e.cnt));
        chk("v", int'(e.tid), 32'(v), 32'(ev));
        for (int i = 0; i < 4; i++)
          chk($sformatf("rd%0d", i), int'(e.tid), rd[i*32 +: 32], e.r[i*32 +: 32]);
        chk("busy", int'(e.tid), 32'(busy), 32'(e.cnt > 5'd12));
        chk("almost_full", int'(e.tid), 32'(almost_full), 32'(e.cnt >= 5'd12));
        chk("ovf_err", int'(e.tid), 32'(ovf_err), 32'(e.o));
        chk("unf_err", int'(e.tid), 32'(unf_err), 32'(e.u));
      end
    end
  end

  // Drive one cycle (active-high masks) and queue the state expected after its edge.
  task automatic cyc(input int tid, input bit rst, input bit fl,
                     input logic [3:0] wa, input logic [3:0] ra,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2, input logic [31:0] d3,
                     input int ec,
                     input logic [31:0] e0, input logic [31:0] e1,
                     input logic [31:0] e2, input logic [31:0] e3,
                     input bit eo, input bit eu);
    exp_t e;
    @(negedge clk);
    #1;
    reset = rst;
    flush = ~fl;
    we    = ~wa;
    re    = ~ra;
    wd    = {d3, d2, d1, d0};
    e.tid = 8'(tid);
    e.cnt = 5'(ec);
    e.r   = {e3, e2, e1, e0};
    e.o   = eo;
    e.u   = eu;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b1;
    we    = 4'hF;
    re    = 4'hF;
    wd    = '0;

    // 1: reset held three cycles, then released idle
    for (int k = 0; k < 3; k++)
      cyc(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0);

    // 2: sparse write compacts wd[0], wd[2]; then drain
    cyc(2, 0, 0, 4'b0101, 4'b0000, A, J, C, J,    2, A, C, 0, 0, 0, 0);
    cyc(2, 0, 0, 4'b0000, 4'b0011, J, J, J, J,    0, 0, 0, 0, 0, 0, 0);

    // 3: fill to 12 (almost_full), to 16 (busy), then a dropped write
    cyc(3, 0, 0, 4'b1111, 4'b0000, 32'h10, 32'h11, 32'h12, 32'h13,  4, 32'h10, 32'h11, 32'h12, 32'h13, 0, 0);
    cyc(3, 0, 0, 4'b1111, 4'b0000, 32'h14, 32'h15, 32'h16, 32'h17,  8, 32'h10, 32'h11, 32'h12, 32'h13, 0, 0);
    cyc(3, 0, 0, 4'b1111, 4'b0000, 32'h18, 32'h19, 32'h1A, 32'h1B, 12, 32'h10, 32'h11, 32'h12, 32'h13, 0, 0);
    cyc(3, 0, 0, 4'b1111, 4'b0000, 32'h1C, 32'h1D, 32'h1E, 32'h1F, 16, 32'h10, 32'h11, 32'h12, 32'h13, 0, 0);
    cyc(3, 0, 0, 4'b0001, 4'b0000, 32'h99, J, J, J,                16, 32'h10, 32'h11, 32'h12, 32'h13, 1, 0);

    // 4: full + read 2 + write 2: reads do not free space, write dropped
    cyc(4, 0, 0, 4'b0011, 4'b0011, 32'h77, 32'h78, J, J, 14, 32'h12, 32'h13, 32'h14, 32'h15, 1, 0);
    // write exactly filling free space alongside a read, then top up to full
    cyc(4, 0, 0, 4'b0011, 4'b0011, 32'h20, 32'h21, J, J, 14, 32'h14, 32'h15, 32'h16, 32'h17, 1, 0);
    cyc(4, 0, 0, 4'b0011, 4'b0000, 32'h22, 32'h23, J, J, 16, 32'h14, 32'h15, 32'h16, 32'h17, 1, 0);
    // drain across the 15 -> 0 wrap, order preserved
    cyc(4, 0, 0, 4'b0000, 4'b1111, J, J, J, J, 12, 32'h18, 32'h19, 32'h1A, 32'h1B, 1, 0);
    cyc(4, 0, 0, 4'b0000, 4'b1111, J, J, J, J,  8, 32'h1C, 32'h1D, 32'h1E, 32'h1F, 1, 0);
    cyc(4, 0, 0, 4'b0000, 4'b1111, J, J, J, J,  4, 32'h20, 32'h21, 32'h22, 32'h23, 1, 0);
    cyc(4, 0, 0, 4'b0000, 4'b0001, J, J, J, J,  3, 32'h21, 32'h22, 32'h23, 0,      1, 0);

    // 5: non-prefix read pops one and flags; over-read clamps to empty
    cyc(5, 0, 0, 4'b0000, 4'b0101, J, J, J, J,  2, 32'h22, 32'h23, 0, 0, 1, 1);
    cyc(5, 0, 0, 4'b0000, 4'b1111, J, J, J, J,  0, 0, 0, 0, 0,           1, 1);

    // 6: fill to 7, flush with writes, refill, then reset mid-stream
    cyc(6, 0, 0, 4'b1111, 4'b0000, 32'h30, 32'h31, 32'h32, 32'h33, 4, 32'h30, 32'h31, 32'h32, 32'h33, 1, 1);
    cyc(6, 0, 0, 4'b0111, 4'b0000, 32'h34, 32'h35, 32'h36, J,      7, 32'h30, 32'h31, 32'h32, 32'h33, 1, 1);
    cyc(6, 0, 1, 4'b1111, 4'b0000, 32'h50, 32'h51, 32'h52, 32'h53, 0, 0, 0, 0, 0, 1, 1);
    cyc(6, 0, 0, 4'b0011, 4'b0000, 32'h40, 32'h41, J, J,           2, 32'h40, 32'h41, 0, 0, 1, 1);
    cyc(6, 1, 0, 4'b1111, 4'b1111, 32'h60, 32'h61, 32'h62, 32'h63, 0, 0, 0, 0, 0, 0, 0);
    cyc(6, 0, 0, 4'b0000, 4'b0000, J, J, J, J,                     0, 0, 0, 0, 0, 0, 0);

    // 7: read from empty flags underflow alone, and it stays set
    cyc(7, 0, 0, 4'b0000, 4'b0001, J, J, J, J, 0, 0, 0, 0, 0, 0, 1);
    cyc(7, 0, 0, 4'b0000, 4'b0000, J, J, J, J, 0, 0, 0, 0, 0, 0, 1);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      ntests++;
      nfail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
